// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core (lw, sw, R/I ALU, beq, jal).
// Optional macro ILLEGAL_TRAP_EN: unsupported opcodes halt in TRAP and raise illegal_instr.
module multicycle_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       instr_done,
    output logic       mem_timeout
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic       illegal_instr
`endif
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, ERROR
`ifdef ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    state_t     state, next_state;
    logic [7:0] wait_cnt;
    logic       mem_state;
    logic       pc_update, branch;
    logic       req_raw, wr_raw, irw_raw, rw_raw;

    always_comb begin
        next_state = state;
        mem_state  = 1'b0;
        case (state)
            FETCH: begin
                mem_state = 1'b1;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECR;
                    OP_I:         next_state = EXECI;
                    OP_BEQ:       next_state = BEQ;
                    OP_JAL:       next_state = JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:      next_state = TRAP;
`else
                    default:      next_state = FETCH;
`endif
                endcase
            end
            MEMADR:   next_state = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD: begin
                mem_state = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWRITE: begin
                mem_state = 1'b1;
                if (mem_ready) next_state = FETCH;
            end
            MEMWB, ALUWB, BEQ: next_state = FETCH;
            EXECR, EXECI, JAL: next_state = ALUWB;
            ERROR:    next_state = ERROR;
`ifdef ILLEGAL_TRAP_EN
            TRAP:     next_state = TRAP;
`endif
            default:  next_state = FETCH;
        endcase
        // A ready in the final allowed wait cycle still completes the access.
        if (mem_state && !mem_ready && wait_cnt == WAIT_LIM) next_state = ERROR;
    end

    always_comb begin
        req_raw    = 1'b0;
        wr_raw     = 1'b0;
        irw_raw    = 1'b0;
        rw_raw     = 1'b0;
        adr_src    = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        case (state)
            FETCH: begin
                req_raw    = 1'b1;
                irw_raw    = mem_ready;
                pc_update  = mem_ready;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: begin
                req_raw = 1'b1;
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                rw_raw     = 1'b1;
            end
            MEMWRITE: begin
                req_raw = 1'b1;
                wr_raw  = 1'b1;
                adr_src = 1'b1;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB: rw_raw = 1'b1;
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated so a reset edge never coincides with a write.
    assign mem_req   = reset_n & req_raw;
    assign mem_write = reset_n & wr_raw;
    assign ir_write  = reset_n & irw_raw;
    assign reg_write = reset_n & rw_raw;
    assign pc_write  = reset_n & (pc_update | (branch & zero));

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = (state == TRAP);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= FETCH;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
            instr_done  <= 1'b0;
        end else begin
            state      <= next_state;
            instr_done <= (next_state == FETCH) && (state != FETCH);
            if (next_state == ERROR) mem_timeout <= 1'b1;
            if (next_state != state)
                wait_cnt <= 8'd0;
            else if (mem_state && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus hand sequences
// for timeout, ready-wins, reset during a write, and unsupported opcodes.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic       zero, mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
    logic       instr_done, mem_timeout;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.MAX_WAIT(15)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .imm_src(imm_src), .instr_done(instr_done),
        .mem_timeout(mem_timeout)
`ifdef ILLEGAL_TRAP_EN
        , .illegal_instr(illegal_instr)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
    localparam logic [6:0] ILL = 7'b1111111;

    // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, a, b, alu_op, result_src}
    localparam logic [13:0] P_RST  = {6'b000000, 8'b00_10_00_10};
    localparam logic [13:0] P_FW   = {6'b100000, 8'b00_10_00_10};
    localparam logic [13:0] P_FR   = {6'b100110, 8'b00_10_00_10};
    localparam logic [13:0] P_DEC  = {6'b000000, 8'b01_01_00_00};
    localparam logic [13:0] P_MADR = {6'b000000, 8'b10_01_00_00};
    localparam logic [13:0] P_MRD  = {6'b101000, 8'b00_00_00_00};
    localparam logic [13:0] P_MWB  = {6'b000001, 8'b00_00_00_01};
    localparam logic [13:0] P_MWR  = {6'b111000, 8'b00_00_00_00};
    localparam logic [13:0] P_MWRR = {6'b001000, 8'b00_00_00_00};
    localparam logic [13:0] P_EXR  = {6'b000000, 8'b10_00_10_00};
    localparam logic [13:0] P_EXI  = {6'b000000, 8'b10_01_10_00};
    localparam logic [13:0] P_AWB  = {6'b000001, 8'b00_00_00_00};
    localparam logic [13:0] P_BEQT = {6'b000010, 8'b10_00_01_00};
    localparam logic [13:0] P_BEQN = {6'b000000, 8'b10_00_01_00};
    localparam logic [13:0] P_JAL  = {6'b000010, 8'b01_10_00_00};
    localparam logic [13:0] P_ERR  = 14'b0;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        zero;
        logic        rdy;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic [6:0] o, input logic z,
                                input logic rdy, input logic [13:0] st,
                                input logic [1:0] imm, input logic done);
        vec_t v;
        v.rst = rst; v.op = o; v.zero = z; v.rdy = rdy;
        v.exp = {st, imm, done, 1'b0};
        tbl.push_back(v);
    endfunction

    // Drive on the falling edge, compare once the combinational outputs settle.
    task automatic apply(input logic rst, input logic [6:0] o, input logic z,
                         input logic rdy, input logic [17:0] exp, input string name);
        logic [17:0] act;
        @(negedge clk);
        reset_n = rst; op = o; zero = z; mem_ready = rdy;
        #1;
        act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src, instr_done, mem_timeout};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; op = RT; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        add(0, RT, 0, 1, P_RST,  2'b00, 0);
        add(1, RT, 0, 1, P_FR,   2'b00, 0);
        add(1, RT, 0, 0, P_DEC,  2'b00, 0);
        add(1, RT, 0, 1, P_EXR,  2'b00, 0);
        add(1, RT, 0, 0, P_AWB,  2'b00, 0);
        add(1, IT, 0, 1, P_FR,   2'b00, 1);
        add(1, IT, 0, 0, P_DEC,  2'b00, 0);
        add(1, IT, 0, 0, P_EXI,  2'b00, 0);
        add(1, IT, 0, 0, P_AWB,  2'b00, 0);
        add(1, LW, 0, 1, P_FR,   2'b00, 1);
        add(1, LW, 0, 0, P_DEC,  2'b00, 0);
        add(1, LW, 0, 1, P_MADR, 2'b00, 0);
        add(1, LW, 0, 0, P_MRD,  2'b00, 0);
        add(1, LW, 0, 0, P_MRD,  2'b00, 0);
        add(1, LW, 0, 1, P_MRD,  2'b00, 0);
        add(1, LW, 0, 0, P_MWB,  2'b00, 0);
        add(1, SW, 0, 1, P_FR,   2'b01, 1);
        add(1, SW, 0, 0, P_DEC,  2'b01, 0);
        add(1, SW, 0, 0, P_MADR, 2'b01, 0);
        add(1, SW, 0, 1, P_MWR,  2'b01, 0);
        add(1, BQ, 1, 1, P_FR,   2'b10, 1);
        add(1, BQ, 1, 0, P_DEC,  2'b10, 0);
        add(1, BQ, 1, 0, P_BEQT, 2'b10, 0);
        add(1, BQ, 0, 1, P_FR,   2'b10, 1);
        add(1, BQ, 0, 0, P_DEC,  2'b10, 0);
        add(1, BQ, 0, 0, P_BEQN, 2'b10, 0);
        add(1, JL, 0, 1, P_FR,   2'b11, 1);
        add(1, JL, 0, 0, P_DEC,  2'b11, 0);
        add(1, JL, 0, 0, P_JAL,  2'b11, 0);
        add(1, JL, 0, 0, P_AWB,  2'b11, 0);
        add(1, ILL, 0, 1, P_FR,  2'b00, 1);
        add(1, ILL, 0, 1, P_DEC, 2'b00, 0);

        foreach (tbl[i])
            apply(tbl[i].rst, tbl[i].op, tbl[i].zero, tbl[i].rdy, tbl[i].exp,
                  $sformatf("tbl[%0d]", i));

`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            apply(1, ILL, 0, 1, {P_ERR, 2'b00, 1'b0, 1'b0}, $sformatf("trap_hold%0d", i));
            checks++;
            if (illegal_instr !== 1'b1) begin
                errors++;
                $display("FAIL trap_flag%0d: got %b expected 1", i, illegal_instr);
            end
        end
`else
        apply(1, ILL, 0, 0, {P_FW, 2'b00, 1'b1, 1'b0}, "nop_retire");
`endif

        // Timeout: 16 waiting cycles in FETCH, then ERROR until reset.
        @(negedge clk); reset_n = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 16; i++)
            apply(1, RT, 0, 0, {P_FW, 2'b00, 1'b0, 1'b0}, $sformatf("wait%0d", i));
        for (int i = 0; i < 3; i++)
            apply(1, RT, 0, 1, {P_ERR, 2'b00, 1'b0, 1'b1}, $sformatf("error%0d", i));
        apply(0, RT, 0, 1, {P_ERR, 2'b00, 1'b0, 1'b1}, "error_rst");
        apply(1, RT, 0, 0, {P_FW, 2'b00, 1'b0, 1'b0}, "tmo_cleared");

        // Ready arriving in the last allowed wait cycle wins over the timeout.
        for (int i = 2; i <= 15; i++)
            apply(1, RT, 0, 0, {P_FW, 2'b00, 1'b0, 1'b0}, $sformatf("rw_wait%0d", i));
        apply(1, RT, 0, 1, {P_FR, 2'b00, 1'b0, 1'b0}, "ready_wins");
        apply(1, RT, 0, 0, {P_DEC, 2'b00, 1'b0, 1'b0}, "ready_wins_dec");
        apply(1, RT, 0, 0, {P_EXR, 2'b00, 1'b0, 1'b0}, "rw_execr");
        apply(1, RT, 0, 0, {P_AWB, 2'b00, 1'b0, 1'b0}, "rw_aluwb");

        // Reset sampled during MEMWRITE suppresses the write and returns to FETCH.
        apply(1, SW, 0, 1, {P_FR, 2'b01, 1'b1, 1'b0}, "sw_fetch");
        apply(1, SW, 0, 0, {P_DEC, 2'b01, 1'b0, 1'b0}, "sw_dec");
        apply(1, SW, 0, 0, {P_MADR, 2'b01, 1'b0, 1'b0}, "sw_madr");
        apply(0, SW, 0, 1, {P_MWRR, 2'b01, 1'b0, 1'b0}, "sw_rst_write");
        apply(1, SW, 0, 0, {P_FW, 2'b01, 1'b0, 1'b0}, "sw_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
